// File: rtl/fp_argext_stream.sv
// Streaming arg-max/arg-min over one frame of sign/exponent/mantissa floats.
// The winning element, its index, the frame count and NaN/overflow flags are held on a result handshake.
module fp_argext_stream #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_data,
  input  logic                 in_last,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_value,
  output logic [IDX_W-1:0]     out_index,
  output logic [IDX_W:0]       out_count,
  output logic                 out_nan,
  output logic                 out_ovf
);

  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W;
  localparam int unsigned CNT_W      = IDX_W + 1;

  typedef enum logic {S_ACC, S_RESULT} state_t;

  state_t state_q, state_d;

  logic                  mode_q;
  logic                  in_frame_q;
  logic                  accept;
  logic                  new_nan;
  logic                  best_nan;
  logic                  better;
  logic                  take_new;
  logic                  elem_ovf;
  logic [DATA_WIDTH-1:0] new_key;
  logic [DATA_WIDTH-1:0] best_key;
  logic [IDX_W-1:0]      elem_idx;

  // Monotonic unsigned key: negatives map below positives, both zeros collapse to +0.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-2:0] mag;
    mag = d[DATA_WIDTH-2:0];
    if (mag == '0)
      order_key = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else if (d[DATA_WIDTH-1])
      order_key = {1'b0, ~mag};
    else
      order_key = {1'b1, mag};
  endfunction

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] d);
    is_nan = (d[DATA_WIDTH-2 -: EXP_W] == {EXP_W{1'b1}}) && (d[MAN_W-1:0] != '0);
  endfunction

  assign accept   = in_valid && in_ready;
  assign new_key  = order_key(in_data);
  assign best_key = order_key(out_value);
  assign new_nan  = is_nan(in_data);
  assign best_nan = is_nan(out_value);
  assign better   = mode_q ? (new_key < best_key) : (new_key > best_key);
  // A NaN never wins; a held NaN (frame opened with NaN) yields to any real value.
  assign take_new = !new_nan && (best_nan || better);

  // Counter MSB set means this element sits beyond the representable index range.
  assign elem_ovf = out_count[IDX_W];
  assign elem_idx = elem_ovf ? {IDX_W{1'b1}} : out_count[IDX_W-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_ACC;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:    if (accept && in_last) state_d = S_RESULT;
      S_RESULT: if (out_ready)         state_d = S_ACC;
      default:  state_d = S_ACC;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_ACC:    in_ready  = 1'b1;
      S_RESULT: out_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  // Running extreme; the accumulator doubles as the held result while in S_RESULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_value  <= '0;
      out_index  <= '0;
      out_count  <= '0;
      out_nan    <= 1'b0;
      out_ovf    <= 1'b0;
      mode_q     <= 1'b0;
      in_frame_q <= 1'b0;
    end else if (accept) begin
      in_frame_q <= !in_last;
      if (!in_frame_q) begin
        out_value <= in_data;
        out_index <= '0;
        out_count <= CNT_W'(1);
        out_nan   <= new_nan;
        out_ovf   <= 1'b0;
        mode_q    <= mode;
      end else begin
        if (take_new) begin
          out_value <= in_data;
          out_index <= elem_idx;
        end
        if (out_count != {CNT_W{1'b1}}) out_count <= out_count + CNT_W'(1);
        out_nan <= out_nan | new_nan;
        out_ovf <= out_ovf | elem_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_argext_stream.sv
// Bench for fp_argext_stream: directed frames plus randomized frames against a numeric reference model.
module tb_fp_argext_stream;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned DW    = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic [DW-1:0]    v;
    logic [IDX_W-1:0] i;
    logic [IDX_W:0]   c;
    logic             n;
    logic             o;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_value;
  logic [IDX_W-1:0] out_index;
  logic [IDX_W:0]   out_count;
  logic             out_nan;
  logic             out_ovf;

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] frame[$];

  fp_argext_stream #(.EXP_W(EXP_W), .MAN_W(MAN_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_index(out_index), .out_count(out_count),
    .out_nan(out_nan), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t observed();
    return {out_value, out_index, out_count, out_nan, out_ovf};
  endfunction

  function automatic res_t mk(input logic [DW-1:0] v, input int i, input int c, input bit n, input bit o);
    res_t r;
    r.v = v; r.i = IDX_W'(i); r.c = (IDX_W+1)'(c); r.n = n; r.o = o;
    return r;
  endfunction

  // Reference: floats as signed integers (+/-magnitude), NaNs skipped, strict compare keeps earliest.
  function automatic res_t model(input logic m);
    res_t r;
    int best, bestv, n, mag, val;
    bit nan;
    logic [DW-1:0] d;
    r = '0; best = -1; bestv = 0; n = frame.size();
    for (int i = 0; i < n; i++) begin
      d   = frame[i];
      mag = int'(d[DW-2:0]);
      val = d[DW-1] ? -mag : mag;
      nan = (d[DW-2:MAN_W] == {EXP_W{1'b1}}) && (d[MAN_W-1:0] != '0);
      if (nan) r.n = 1'b1;
      else if (best < 0 || (m ? (val < bestv) : (val > bestv))) begin
        best = i; bestv = val;
      end
    end
    if (best < 0) best = 0;
    r.v = frame[best];
    r.i = (best >= (1 << IDX_W)) ? {IDX_W{1'b1}} : IDX_W'(best);
    r.c = (n > (1 << (IDX_W + 1)) - 1) ? {(IDX_W+1){1'b1}} : (IDX_W+1)'(n);
    r.o = (n > (1 << IDX_W));
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_elem();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 5))
      0:       return {s, 5'h1F, 10'h000};
      1:       return {s, 5'h1F, 10'($urandom_range(1, 1023))};
      2:       return {s, 15'h0000};
      3:       return {s, 15'h3C00};
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL in_ready_timeout: in_ready=%b want 1", in_ready);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the final element is accepted.
  task automatic drive_frame(input logic m, input bit close, input bit gaps);
    for (int i = 0; i < frame.size(); i++) begin
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = close && (i == frame.size() - 1);
      mode     = (i == 0) ? m : 1'($urandom);
      wait_ready();
      @(negedge clk);
      if (gaps && i < frame.size() - 1 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_last = 1'($urandom); in_data = DW'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid} !== 2'b10 || observed() !== '0) begin
      miscompares++;
      $display("FAIL reset: ready/valid=%b%b res=%h want 10 res=0", in_ready, out_valid, observed());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max_min();
    res_t exp_r;
    frame = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800};
    drive_frame(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({out_valid, in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL latency_max: valid/ready=%b%b want 10", out_valid, in_ready);
    end
    exp_r = mk(16'h4000, 1, 4, 1'b0, 1'b0);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL argmax: got %h want %h", observed(), exp_r);
    end
    consume();
    drive_frame(1'b1, 1'b1, 1'b0);
    exp_r = mk(16'hC000, 2, 4, 1'b0, 1'b0);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL argmin: got %h want %h", observed(), exp_r);
    end
    consume();
    frame = '{16'h3C00, 16'h3C00};
    drive_frame(1'b0, 1'b1, 1'b0);
    exp_r = mk(16'h3C00, 0, 2, 1'b0, 1'b0);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL tie_first: got %h want %h", observed(), exp_r);
    end
    consume();
  endtask

  task automatic test_zeros_nan();
    res_t exp_r;
    frame = '{16'h8000, 16'h0000};
    drive_frame(1'b0, 1'b1, 1'b0);
    exp_r = mk(16'h8000, 0, 2, 1'b0, 1'b0);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL signed_zero: got %h want %h", observed(), exp_r);
    end
    consume();
    frame = '{16'h7E00, 16'h3C00, 16'hFC00};
    drive_frame(1'b0, 1'b1, 1'b0);
    exp_r = mk(16'h3C00, 1, 3, 1'b1, 1'b0);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL nan_first: got %h want %h", observed(), exp_r);
    end
    consume();
  endtask

  task automatic test_backpressure();
    res_t exp_r;
    frame = '{16'h4400, 16'hBC00, 16'h4400};
    drive_frame(1'b1, 1'b1, 1'b0);
    exp_r = mk(16'hBC00, 1, 3, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'hFBFF; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({out_valid, in_ready} !== 2'b10 || observed() !== exp_r) begin
        miscompares++;
        $display("FAIL hold_%0d: valid/ready=%b%b res=%h want 10 res=%h", k, out_valid, in_ready,
                 observed(), exp_r);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL after_handshake: valid/ready=%b%b want 01", out_valid, in_ready);
    end
    frame = '{16'hC400};
    drive_frame(1'b0, 1'b1, 1'b0);
    exp_r = mk(16'hC400, 0, 1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || observed() !== exp_r) begin
      miscompares++;
      $display("FAIL back_to_back: valid=%b got %h want 1 %h", out_valid, observed(), exp_r);
    end
    consume();
  endtask

  task automatic test_overflow();
    res_t exp_r;
    frame = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800, 16'h4400, 16'h7C00};
    drive_frame(1'b0, 1'b1, 1'b0);
    exp_r = mk(16'h7C00, 3, 6, 1'b0, 1'b1);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL overflow_idx: got %h want %h", observed(), exp_r);
    end
    consume();
    frame = '{16'h3C00, 16'h3800, 16'h7BFF, 16'h3C00, 16'h3C00,
              16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    drive_frame(1'b0, 1'b1, 1'b0);
    exp_r = mk(16'h7BFF, 2, 7, 1'b0, 1'b1);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL count_saturate: got %h want %h", observed(), exp_r);
    end
    consume();
  endtask

  task automatic test_rst_midframe();
    res_t exp_r;
    frame = '{16'h3C00, 16'h4400};
    drive_frame(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, in_ready} !== 2'b01 || observed() !== '0) begin
      miscompares++;
      $display("FAIL rst_midframe: valid/ready=%b%b res=%h want 01 res=0", out_valid, in_ready, observed());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame = '{16'h4200};
    drive_frame(1'b0, 1'b1, 1'b0);
    exp_r = mk(16'h4200, 0, 1, 1'b0, 1'b0);
    vectors++;
    if (observed() !== exp_r) begin
      miscompares++; $display("FAIL fresh_after_rst: got %h want %h", observed(), exp_r);
    end
    consume();
  endtask

  task automatic test_random();
    res_t exp_r;
    int   len, hold;
    logic m;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 10);
      m   = 1'($urandom);
      frame.delete();
      repeat (len) frame.push_back(rnd_elem());
      exp_r = model(m);
      drive_frame(m, 1'b1, 1'b1);
      vectors++;
      if ({out_valid, in_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL rand_latency_%0d: valid/ready=%b%b want 10", f, out_valid, in_ready);
      end
      hold = $urandom_range(0, 3);
      in_valid = 1'($urandom); in_data = DW'($urandom); in_last = 1'b1;
      repeat (hold) @(negedge clk);
      vectors++;
      if (observed() !== exp_r) begin
        miscompares++;
        $display("FAIL rand_frame_%0d: mode=%b len=%0d got %h want %h", f, m, len, observed(), exp_r);
      end
      consume();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_max_min();
    test_zeros_nan();
    test_backpressure();
    test_overflow();
    test_rst_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
